fwrisc_imem_responder: RTL

- Instruction-memory responder for the fwrisc fetch bus (iaddr/idata/ivalid/iready); the target side answering fwrisc_fetch requests.
- Word-organised storage, preloaded through a load port.
- Configurable fixed wait states plus an external stall input, so fetch benches and formal harnesses can exercise variable bus latency.
- Counts completed transfers and flags out-of-range accesses.

---
 rtl/fwrisc_imem_responder.sv | 91 +++++++++
 1 files changed

// File: rtl/fwrisc_imem_responder.sv
// fwrisc_imem_responder: word memory answering fwrisc fetch requests with wait states, stall and error flag
module fwrisc_imem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] iaddr,
  input  logic        ivalid,
  output logic [31:0] idata,
  output logic        iready,
  output logic        ierr,
  input  logic        stall,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [15:0] xfer_count
);
  localparam int          AW      = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] idata_q, idata_d;
  logic        ierr_q, ierr_d;
  logic [15:0] xfer_q, xfer_d;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_addr, rd_idx, ld_idx, rd_word;
  logic        rd_ok, ld_ok, expired;
  assign rd_addr    = state_q == IDLE ? iaddr : req_addr_q;
  assign rd_idx     = (rd_addr - BASE_ADDR) >> 2;
  assign ld_idx     = (load_addr - BASE_ADDR) >> 2;
  assign rd_ok      = rd_idx < DEPTH_W;
  assign ld_ok      = ld_idx < DEPTH_W;
  assign rd_word    = mem[rd_idx[AW-1:0]];
  assign expired    = cnt_q >= WS;
  assign iready     = state_q == RESP;
  assign idata      = idata_q;
  assign ierr       = ierr_q;
  assign xfer_count = xfer_q;
  // next state; read data is captured only on the edge entering RESP and is zero otherwise
  always_comb begin
    state_d    = state_q;
    cnt_d      = 4'd0;
    req_addr_d = req_addr_q;
    xfer_d     = xfer_q;
    unique case (state_q)
      IDLE: if (ivalid) begin
        req_addr_d = iaddr;
        state_d    = (WS != 4'd0 || stall) ? WAIT : RESP;
        cnt_d      = 4'd1;
      end
      WAIT: begin
        state_d = !ivalid ? IDLE : (expired && !stall) ? RESP : WAIT;
        cnt_d   = expired ? cnt_q : cnt_q + 4'd1;
      end
      RESP: begin
        state_d = IDLE;
        xfer_d  = ivalid ? xfer_q + 16'd1 : xfer_q;
      end
      default: state_d = IDLE;
    endcase
    idata_d = (state_d == RESP && rd_ok) ? rd_word : 32'd0;
    ierr_d  = state_d == RESP && !rd_ok;
  end
  // control and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      req_addr_q <= 32'd0;
      idata_q    <= 32'd0;
      ierr_q     <= 1'b0;
      xfer_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      idata_q    <= idata_d;
      ierr_q     <= ierr_d;
      xfer_q     <= xfer_d;
    end
  end
  // preload port; memory survives reset and out-of-range writes are dropped
  always_ff @(posedge clock) begin
    if (load_en && ld_ok) mem[ld_idx[AW-1:0]] <= load_data;
  end
endmodule
